// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants used by the fetch path.
package riscv_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;
endpackage

// File: rtl/prefetch_fifo.sv
// Show-ahead FIFO with synchronous push/pop and single-cycle flush.
module prefetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/instruction_prefetch_unit.sv
// Fetch front-end: credit-limited sequential fetch, in-order response queue, redirect flush.
module instruction_prefetch_unit #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [riscv_pkg::INSTR_W-1:0] imem_rsp_data,
  output logic                          if_valid,
  output logic [XLEN-1:0]               if_pc,
  output logic [riscv_pkg::INSTR_W-1:0] if_instruction
);
  import riscv_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = XLEN + INSTR_W;

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_in_flight;
  logic [CW-1:0]   r_discard;
  logic [XLEN-1:0] r_tag [DEPTH];
  logic [AW-1:0]   r_tag_wr;
  logic [AW-1:0]   r_tag_rd;
  logic [XLEN-1:0] r_last_pc;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit_used;
  logic [EW-1:0]   w_head;
  logic [XLEN-1:0] w_head_pc;

  // Queued plus outstanding entries bound the queue, so a response always has a slot.
  assign w_credit_used  = {1'b0, w_count} + {1'b0, r_in_flight};
  assign imem_req_valid = reset && !redirect && !w_fifo_full
                          && (w_credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_push         = imem_rsp_valid && (r_discard == '0) && !redirect;
  assign w_pop          = !w_fifo_empty && !stall && !redirect;

  assign w_head_pc      = w_head[EW-1:INSTR_W];
  assign if_valid       = !w_fifo_empty;
  assign if_pc          = w_fifo_empty ? r_last_pc : w_head_pc;
  assign if_instruction = w_fifo_empty ? NOP_INSTR : w_head[INSTR_W-1:0];

  prefetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data ({r_tag[r_tag_rd], imem_rsp_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc  <= RESET_PC;
      r_in_flight <= '0;
      r_discard   <= '0;
      r_tag_wr    <= '0;
      r_tag_rd    <= '0;
      r_last_pc   <= '0;
    end else begin
      if (w_accept)       r_tag_wr <= r_tag_wr + 1'b1;
      if (imem_rsp_valid) r_tag_rd <= r_tag_rd + 1'b1;
      if (!w_fifo_empty)  r_last_pc <= w_head_pc;

      // Every outstanding response except one landing now must be dropped after a redirect.
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_discard  <= r_in_flight - CW'(imem_rsp_valid);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
        if (imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      end

      case ({w_accept, imem_rsp_valid})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tag[r_tag_wr] <= r_fetch_pc;
  end
endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit with an in-order fixed-latency memory model.
module tb_instruction_prefetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_req_ready;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_instruction;

  int unsigned n_chk   = 0;
  int unsigned n_err   = 0;
  int unsigned cyc     = 0;
  int unsigned mem_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t mq[$];

  always #5 clk = ~clk;

  instruction_prefetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
  );

  // Memory: request accepted at edge P answers in the cycle ending at edge P+mem_lat.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      cyc++;
      if (imem_req_valid && imem_req_ready)
        mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat - 1});
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].addr ^ KEY;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Every presented instruction must be the next expected pc; bubbles allowed.
  task automatic expect_stream(input logic [31:0] first, input int n, input int budget);
    logic [31:0] exp_pc;
    int got;
    exp_pc = first;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (if_valid) begin
        check("stream_pc", if_pc, exp_pc);
        check("stream_instr", if_instruction, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    if (got < n) check("stream_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
    tick(); tick();
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instruction, NOP);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);

    // 1: back-to-back fetch with 1-cycle memory
    reset = 1'b1; #1;
    check("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("t1_c1_addr", imem_req_addr, 32'h0);
    check("t1_c1_if_valid", 32'(if_valid), 32'd0);
    tick();
    check("t1_c2_addr", imem_req_addr, 32'h4);
    check("t1_c2_if_valid", 32'(if_valid), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("t1_if_valid", 32'(if_valid), 32'd1);
      check("t1_if_pc", if_pc, 32'(4 * i));
      check("t1_if_instr", if_instruction, 32'(4 * i) ^ KEY);
      tick();
    end

    // 2: stall five cycles, queue fills, then drains in order with no gaps
    stall = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(if_valid), 32'd1);
      check("t2_hold_pc", if_pc, 32'd24);
      check("t2_req_valid", 32'(imem_req_valid), (i >= 2) ? 32'd0 : 32'd1);
      tick();
    end
    stall = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      check("t2_resume_valid", 32'(if_valid), 32'd1);
      check("t2_resume_pc", if_pc, 32'(24 + 4 * i));
      tick();
    end

    // 3: redirect with three requests outstanding on a 3-cycle memory
    reset = 1'b0; #1;
    mem_lat = 3;
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100; #1;
    check("t3_R_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0; #1;
    check("t3_R1_req_valid", 32'(imem_req_valid), 32'd1);
    check("t3_R1_addr", imem_req_addr, 32'h0000_0100);
    expect_stream(32'h0000_0100, 3, 20);

    // 4: redirect beats a simultaneous stall; low address bits are cleared
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0203; #1;
    check("t4_R_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    stall = 1'b0; redirect = 1'b0; #1;
    check("t4_R1_if_valid", 32'(if_valid), 32'd0);
    check("t4_R1_addr", imem_req_addr, 32'h0000_0200);
    expect_stream(32'h0000_0200, 3, 20);

    // 5: fetch address wraps past the top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
    tick();
    redirect = 1'b0; #1;
    check("t5_R1_addr", imem_req_addr, 32'hFFFF_FFF8);
    expect_stream(32'hFFFF_FFF8, 4, 20);

    // 6: reset with a full queue, then clean restart
    stall = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t6_full_valid", 32'(if_valid), 32'd1);
    check("t6_full_pc", if_pc, 32'h0000_0008);
    check("t6_full_req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b0; #1;
    check("t6_rst_if_valid", 32'(if_valid), 32'd0);
    check("t6_rst_instr", if_instruction, NOP);
    check("t6_rst_if_pc", if_pc, 32'h0);
    check("t6_rst_addr", imem_req_addr, 32'h0);
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    mem_lat = 1;
    stall = 1'b0;
    tick(); tick();
    reset = 1'b1; #1;
    check("t6_c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("t6_c1_addr", imem_req_addr, 32'h0);
    expect_stream(32'h0, 4, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
